// File: rtl/hr_bridge_fifo_pkg.sv
// Shared definitions for the hierarchical-ring bridge transfer FIFO.
// Optional cut-through path: define HR_FIFO_BYPASS_EN (undefined by default).
`ifndef CONTROL_W
`define CONTROL_W 144
`endif

package hr_bridge_fifo_pkg;

  localparam int HR_DATA_W = `CONTROL_W;

  localparam int HR_DEPTH = 4;
  localparam int HR_SLACK = 1;

  localparam logic [HR_DATA_W-1:0] HR_FLIT_INVALID = '0;

  function automatic int hr_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hr_fifo_mem.sv
// Flit storage for the bridge FIFO: one write port, one async read port.
// Contents are intentionally not reset; validity is tracked by the owner.
module hr_fifo_mem
    import hr_bridge_fifo_pkg::*;
#(
    parameter int DATA_W = HR_DATA_W,
    parameter int DEPTH  = HR_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the incoming flit into its slot.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hr_bridge_fifo.sv
// Single-direction bridge transfer buffer with registered back-pressure.
// Optional cut-through when empty: define HR_FIFO_BYPASS_EN.
module hr_bridge_fifo
    import hr_bridge_fifo_pkg::*;
#(
    parameter int DATA_W = HR_DATA_W,
    parameter int DEPTH  = HR_DEPTH,
    parameter int SLACK  = HR_SLACK,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enQ_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              deQ_i,
    output logic [DATA_W-1:0] data_o,
    output logic              bfull_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o,
    output logic              ovf_o
);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HIWM = CW'(DEPTH - SLACK);

    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              is_empty;
    logic              is_full;
    logic              pop;
    logic              push;
    logic              bypass;
    logic              wr_en;
    logic [DATA_W-1:0] head;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

`ifdef HR_FIFO_BYPASS_EN
    // Empty FIFO popped in the same cycle it is pushed: flit cuts through.
    assign bypass = is_empty && enQ_i && deQ_i;
`else
    assign bypass = 1'b0;
`endif

    // A pop at full frees a slot on the same edge, so the push still fits.
    assign pop   = deQ_i && !is_empty;
    assign push  = enQ_i && (!is_full || deQ_i);
    assign wr_en = push && !bypass;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (wr_en) begin
            wp_d = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
        if (enQ_i && is_full && !deQ_i) begin
            ovf_d = 1'b1;
        end
    end

    // Occupancy state; storage itself is left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    hr_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wp_q),
        .wdata_i (data_i),
        .raddr_i (rp_q),
        .rdata_o (head)
    );

    // Head flit, or the invalid flit (or cut-through data) when empty.
    always_comb begin
        data_o = head;
        if (is_empty) begin
            data_o = HR_FLIT_INVALID;
`ifdef HR_FIFO_BYPASS_EN
            if (enQ_i) begin
                data_o = data_i;
            end
`endif
        end
    end

    assign bfull_o = (count_q >= CNT_HIWM);
    assign empty_o = is_empty;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_hr_bridge_fifo.sv
// Scoreboard bench for hr_bridge_fifo (DEPTH=4, SLACK=1, DATA_W=144).
// Expected flits queue on push and are compared as the DUT presents them.
module tb_hr_bridge_fifo;

    localparam int DW    = 144;
    localparam int DEPTH = 4;
    localparam int SLACK = 1;
    localparam int CW    = 3;

    localparam logic [DW-1:0] FA =
        {16'hA1A1, 112'h0123456789ABCDEF001122334455, 16'h1857};
    localparam logic [DW-1:0] FB =
        {16'hB2B2, 112'h1111222233334444555566667777, 16'h185f};
    localparam logic [DW-1:0] FC =
        {16'hC3C3, 112'h89898989ABABABABCDCDCDCDEFEF, 16'h1850};
    localparam logic [DW-1:0] FD =
        {16'hD4D4, 112'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 16'h2222};
    localparam logic [DW-1:0] FE =
        {16'hE5E5, 112'hF0F0F0F0F0F0F0F0F0F0F0F0F0F0, 16'h3333};

    logic          clk = 1'b0;
    logic          rst;
    logic          enQ_i;
    logic [DW-1:0] data_i;
    logic          deQ_i;
    logic [DW-1:0] data_o;
    logic          bfull_o;
    logic          empty_o;
    logic [CW-1:0] count_o;
    logic          ovf_o;

    logic [DW-1:0] sb [$];
    logic          m_ovf;
    int            errs   = 0;
    int            checks = 0;

    hr_bridge_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .enQ_i   (enQ_i),
        .data_i  (data_i),
        .deQ_i   (deQ_i),
        .data_o  (data_o),
        .bfull_o (bfull_o),
        .empty_o (empty_o),
        .count_o (count_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_flit();
        return {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    endfunction

    // Checks all outputs against the model, then clocks one cycle.
    task automatic step(input logic e, input logic [DW-1:0] d,
                        input logic q);
        int            n;
        logic [DW-1:0] exp_d;
        logic          do_pop;
        logic          do_push;
        enQ_i  = e;
        data_i = d;
        deQ_i  = q;
        #1;
        n     = sb.size();
        exp_d = (n > 0) ? sb[0] : '0;
`ifdef HR_FIFO_BYPASS_EN
        if (n == 0 && e) exp_d = d;
`endif
        chk("data_o", data_o, exp_d);
        chk("count_o", DW'(count_o), DW'(n));
        chk("bfull_o", DW'(bfull_o), DW'(n >= DEPTH - SLACK));
        chk("empty_o", DW'(empty_o), DW'(n == 0));
        chk("ovf_o", DW'(ovf_o), DW'(m_ovf));
        do_pop  = q && (n > 0);
        do_push = e && (n < DEPTH || q);
`ifdef HR_FIFO_BYPASS_EN
        if (n == 0 && e && q) do_push = 1'b0;
`endif
        if (e && n == DEPTH && !q) m_ovf = 1'b1;
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_count", DW'(count_o), '0);
        chk("rst_data", data_o, '0);
        chk("rst_empty", DW'(empty_o), DW'(1));
        chk("rst_bfull", DW'(bfull_o), '0);
        chk("rst_ovf", DW'(ovf_o), '0);
        sb.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        enQ_i  = 1'b0;
        deQ_i  = 1'b0;
        data_i = '0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Three pushes, then asynchronous reset mid-stream.
        step(1, FA, 0);
        step(1, FB, 0);
        step(1, FC, 0);
        step(0, '0, 0);
        do_reset();

        // Fill, overflow attempt, then drain in order.
        step(1, FA, 0);
        step(1, FB, 0);
        step(1, FC, 0);
        step(1, FD, 0);
        step(1, FE, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1);
        step(0, '0, 0);
        do_reset();

        // Push and pop together while full: no overflow.
        for (int i = 0; i < 4; i++) step(1, rnd_flit(), 0);
        for (int i = 0; i < 3; i++) step(1, rnd_flit(), 1);
        for (int i = 0; i < 4; i++) step(0, '0, 1);
        do_reset();

        // Hold occupancy at two across pointer wrap.
        step(1, FA, 0);
        step(1, FB, 0);
        for (int i = 0; i < 6; i++) step(1, rnd_flit(), 1);
        for (int i = 0; i < 3; i++) step(0, '0, 1);

        // Push with pop into an empty FIFO, then pop while empty.
        step(1, FC, 1);
        step(0, '0, 0);
        step(0, '0, 1);
        step(0, '0, 1);
        step(0, '0, 0);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), rnd_flit(),
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 5; i++) step(0, '0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/hr_bridge_fifo.md
Name: hr_bridge_fifo

Overview:
- Single-direction transfer buffer inside the hierarchical-ring bridge.
- One instance sits on each bridge transfer path (l0, l1, g0..g3). It takes the flit the bridge crossbar pushes with enQ and its FIFO_*_o output.
- It presents its head flit back to the bridge on FIFO_*_i, and reports back-pressure on bfull_*.
- Bridge deQ pops the head after the flit wins a ring slot.

Parameters:
- DATA_W, 144, flit width; equals `control_w.
- DEPTH, 4, number of flit entries; power of two, at least 2.
- SLACK, 1, number of entries kept free when bfull_o asserts; covers the one-cycle enQ decision made on the registered bfull.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enQ_i  in  1  push data_i this cycle.
- data_i  in  DATA_W  flit from the bridge FIFO_*_o.
- deQ_i  in  1  pop the head flit this cycle.
- data_o  out  DATA_W  head flit to the bridge FIFO_*_i; all-zero (invalid flit) when empty.
- bfull_o  out  1  back-pressure to the bridge bfull_*_i.
- empty_o  out  1  no stored flit.
- count_o  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- ovf_o  out  1  sticky: a push was attempted while full.

Behaviour:
- Reset is asynchronous on rst high. It clears the read and write pointers and count to 0, and clears ovf.
- Storage contents are not reset.
- Values during reset: data_o=0, empty_o=1, bfull_o=0, count_o=0, ovf_o=0.
- Storage is a circular buffer. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count is a separate register that never wraps.
- Push (enQ_i=1 and count<DEPTH):
  - writes data_i to mem[wp] at the clock edge and increments wp.
  - The flit is visible on data_o no earlier than the next cycle (1-cycle latency).
- Pop (deQ_i=1 and count>0): increments rp at the edge. data_o shows the next entry, or 0 if the FIFO becomes empty.
- Simultaneous push and pop with 0<count<DEPTH: both happen and count is unchanged.
- Simultaneous push and pop at count=DEPTH: the pop happens; the push is also accepted because a slot frees the same edge. Count stays DEPTH and ovf is not set.
- Simultaneous push and pop at count=0: the pop is ignored and the push is accepted, so count becomes 1. This holds without the optional feature.
- Push with count=DEPTH and no pop: the flit is dropped, state is unchanged, and ovf_o is set (sticky until rst).
- Pop with count=0: ignored, no error.
- data_o = (count==0) ? 0 : mem[rp]. It is a combinational read of registered state.
- bfull_o = (count >= DEPTH-SLACK). It depends only on registers, so there is no path from enQ_i or deQ_i to bfull_o.
- empty_o = (count==0).
- rst asserted mid-stream discards all stored flits immediately. The first push after rst deasserts is stored at entry 0.
- There is no FSM beyond the occupancy counter; there are no further internal states.

Optional Feature:
- Macro HR_FIFO_BYPASS_EN.
- With the macro defined, cut-through is enabled when count==0 and enQ_i=1:
  - data_o=data_i combinationally, in the same cycle.
  - If deQ_i=1 in that cycle, the flit is consumed without being written and count stays 0.
  - If deQ_i=0, the flit is stored as normal.
- Without the macro: data_o is 0 while empty, and a flit pushed into an empty FIFO is always stored and seen the next cycle.

Decomposition:
- Add to the shared defines.v:
  - `control_w / DATA_W = 144.
  - The all-zero invalid-flit constant.
  - The HR_FIFO_BYPASS_EN macro default (undefined).
- One natural sub-module, hr_fifo_mem: DEPTH x DATA_W register array with 1 write port and 1 asynchronous read port.
- Pointer and count logic stays in hr_bridge_fifo.

Test Plan:
- Reset with rst=1 mid-operation after 3 pushes -> immediately count_o=0, data_o=0, empty_o=1, bfull_o=0, ovf_o=0.
- Push A=144'h...1857, B=...185f, C=...1850 on consecutive cycles, no pops -> data_o=A one cycle after the first push. count_o=3 and bfull_o=1 (DEPTH=4, SLACK=1) after the third edge.
- Fill to 4, then push D with no pop -> D dropped, ovf_o=1, count_o=4. Pop four times -> outputs A, B, C, fourth flit in order, then data_o=0 and empty_o=1.
- Hold count=2 with push and pop asserted for 6 cycles -> count_o stays 2, output order is preserved across pointer wrap (entry 3 -> 0).
- Empty FIFO, push X with deQ_i=1 in the same cycle:
  - without the macro -> count_o=1 and data_o=X next cycle.
  - with HR_FIFO_BYPASS_EN -> data_o=X in the same cycle, count_o stays 0.
- Pop with count=0 -> no change, ovf_o stays 0.
